// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: launch FSM encoding and
// default geometry used by both uart_tx_fifo and uart_top_module.
package uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_START = 2'd1;
  localparam logic [1:0] STATE_SEND  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    START = STATE_START,
    SEND  = STATE_SEND
  } tx_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for the transmit FIFO: synchronous write,
// combinational read at the read pointer so the head is visible in IDLE.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  tx_clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge tx_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus launch controller: buffers host bytes and hands them to
// the UART transmitter one frame at a time using the tx_en/busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                     tx_clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     ovf_clr,
  input  logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     start_err,
  output logic                     tx_en,
  output logic [DATA_WIDTH-1:0]    data_in
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT);

  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic                  overflow_reg, start_err_reg;
  tx_state_t             state_reg, state_next;
  logic [TW-1:0]         timer_reg, timer_next;
  logic                  tx_en_reg, tx_en_next;
  logic [DATA_WIDTH-1:0] data_in_reg, data_in_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  full_int, empty_int;
  logic                  push, pop, ovf_event, timeout_event;

  assign full_int  = (count_reg == CW'(DEPTH));
  assign empty_int = (count_reg == '0);
  // Full is the registered view, so a write while full is refused even if
  // the FSM pops in the same cycle.
  assign push      = wr_en && !full_int;
  assign ovf_event = wr_en && full_int;

  uart_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .tx_clk (tx_clk),
    .we     (push),
    .waddr  (wr_ptr_reg),
    .wdata  (wr_data),
    .raddr  (rd_ptr_reg),
    .rdata  (head_data)
  );

  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      start_err_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (ovf_event)    overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (timeout_event) start_err_reg <= 1'b1;
      else if (ovf_clr)  start_err_reg <= 1'b0;
    end
  end

  always_ff @(posedge tx_clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      tx_en_reg   <= 1'b0;
      data_in_reg <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      tx_en_reg   <= tx_en_next;
      data_in_reg <= data_in_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    tx_en_next    = tx_en_reg;
    data_in_next  = data_in_reg;
    pop           = 1'b0;
    timeout_event = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_int && !busy) begin
          pop          = 1'b1;
          data_in_next = head_data;
          tx_en_next   = 1'b1;
          timer_next   = '0;
          state_next   = START;
        end
      end
      START: begin
        if (busy) begin
          tx_en_next = 1'b0;
          state_next = SEND;
        end else if (timer_reg == TW'(START_TIMEOUT - 1)) begin
          // Transmitter never answered: drop the byte and flag it.
          tx_en_next    = 1'b0;
          timeout_event = 1'b1;
          state_next    = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      SEND: begin
        tx_en_next = 1'b0;
        if (!busy) state_next = IDLE;
      end
      default: begin
        tx_en_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign full      = full_int;
  assign empty     = empty_int;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign start_err = start_err_reg;
  assign tx_en     = tx_en_reg;
  assign data_in   = data_in_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a behavioural transmitter answers
// tx_en, a monitor logs launched frames, and each test compares to its model.
module tb_uart_tx_fifo;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 1024;

  logic       tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       ovf_clr = 1'b0;
  logic       busy = 1'b0;
  logic       full, empty, overflow, start_err, tx_en;
  logic [4:0] count;
  logic [7:0] data_in;

  int tests_run = 0;
  int tests_failed = 0;

  // 0 = transmitter model, 1 = busy stuck 1, 2 = busy stuck 0, 3 = driven by test
  int busy_mode = 0;
  int busy_delay = 2;
  int busy_hold = 100;
  int busy_viol = 0;
  logic [7:0] launch_q[$];
  int len_q[$];

  uart_tx_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH), .START_TIMEOUT(TIMEOUT)) dut (
    .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .busy(busy), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .start_err(start_err),
    .tx_en(tx_en), .data_in(data_in)
  );

  always #5 tx_clk = ~tx_clk;

  // Transmitter: busy rises busy_delay cycles after tx_en, stays busy_hold cycles.
  initial begin : xmtr
    int ph;
    int cnt;
    ph = 0;
    cnt = 0;
    forever begin
      @(negedge tx_clk);
      if (busy_mode == 1) begin busy = 1'b1; ph = 0; end
      else if (busy_mode == 2) begin busy = 1'b0; ph = 0; end
      else if (busy_mode == 3) ph = 0;
      else if (ph == 0) begin
        if (!tx_en) busy = 1'b0;
        else if (busy_delay <= 1) begin busy = 1'b1; ph = 2; cnt = 0; end
        else begin ph = 1; cnt = 1; end
      end else if (ph == 1) begin
        cnt++;
        if (cnt >= busy_delay) begin busy = 1'b1; ph = 2; cnt = 0; end
      end else begin
        cnt++;
        if (cnt >= busy_hold) begin busy = 1'b0; ph = 0; end
      end
    end
  end

  // Monitor: log data_in at each tx_en rise and the length of each pulse.
  initial begin : mon
    logic prev;
    int len;
    prev = 1'b0;
    len = 0;
    forever begin
      @(posedge tx_clk); #1;
      if (!rst) begin
        prev = 1'b0;
        len = 0;
      end else begin
        if (tx_en && !prev) begin
          launch_q.push_back(data_in);
          len = 1;
          if (busy) busy_viol++;
        end else if (tx_en) len++;
        else if (prev) len_q.push_back(len);
        prev = tx_en;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge tx_clk);
  endtask

  task automatic drive_write(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge tx_clk);
    wr_en = 1'b0;
  endtask

  task automatic clear_logs;
    launch_q.delete();
    len_q.delete();
    busy_viol = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int i;
    i = 0;
    while (len_q.size() < n && i < budget) begin tick(1); i++; end
    while ((busy || tx_en || !empty) && i < budget) begin tick(1); i++; end
    ok = (i < budget);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #100;
    @(negedge tx_clk);
    rst = 1'b1;
    tick(1);
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", full); end
    tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++; if (tx_en !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
    tests_run++; if (data_in !== 8'd0) begin tests_failed++; $display("FAIL reset_data_in: got %0d want 0", data_in); end
    tests_run++; if (overflow !== 1'b0 || start_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags: got ovf=%b err=%b want 0 0", overflow, start_err);
    end
  endtask

  task automatic test_ordered_drain;
    logic [7:0] exp_q[$];
    bit ok;
    exp_q = '{8'd40, 8'd85, 8'd123};
    busy_mode = 0; busy_delay = 2; busy_hold = 100;
    clear_logs();
    foreach (exp_q[i]) drive_write(exp_q[i]);
    wait_frames(3, 1000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL drain_timeout: got %0d frames want 3", len_q.size()); end
    tests_run++; if (launch_q.size() != 3) begin tests_failed++; $display("FAIL drain_count: got %0d want 3", launch_q.size()); end
    for (int i = 0; i < 3 && i < launch_q.size() && i < len_q.size(); i++) begin
      $display("[TB] drain frame %0d data=%0d pulse=%0d", i, launch_q[i], len_q[i]);
      tests_run++; if (launch_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, launch_q[i], exp_q[i]); end
      tests_run++; if (len_q[i] != 2) begin tests_failed++; $display("FAIL drain_pulse[%0d]: got %0d want 2", i, len_q[i]); end
    end
    tests_run++; if (busy_viol != 0) begin tests_failed++; $display("FAIL drain_busy_launch: got %0d launches during busy want 0", busy_viol); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL drain_empty: got %b want 1", empty); end
  endtask

  task automatic test_random_drain;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit ok;
    int n;
    for (int r = 0; r < 3; r++) begin
      exp_q.delete();
      n = $urandom_range(4, 12);
      busy_delay = $urandom_range(1, 4);
      busy_hold = $urandom_range(2, 20);
      busy_mode = 0;
      clear_logs();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_q.push_back(b);
        drive_write(b);
        tick($urandom_range(0, 15));
      end
      wait_frames(n, 3000, ok);
      tests_run++; if (!ok || launch_q.size() != n) begin
        tests_failed++; $display("FAIL rand_count[%0d]: got %0d want %0d", r, launch_q.size(), n);
      end
      for (int i = 0; i < n && i < launch_q.size() && i < len_q.size(); i++) begin
        $display("[TB] rand round %0d frame %0d data=%0d pulse=%0d", r, i, launch_q[i], len_q[i]);
        tests_run++; if (launch_q[i] !== exp_q[i] || len_q[i] != busy_delay) begin
          tests_failed++;
          $display("FAIL rand_frame[%0d.%0d]: got data=%0d pulse=%0d want data=%0d pulse=%0d",
                   r, i, launch_q[i], len_q[i], exp_q[i], busy_delay);
        end
      end
      tests_run++; if (busy_viol != 0 || overflow !== 1'b0) begin
        tests_failed++; $display("FAIL rand_hazard[%0d]: got viol=%0d ovf=%b want 0 0", r, busy_viol, overflow);
      end
    end
  endtask

  task automatic test_fill_overflow;
    bit ok;
    busy_mode = 1;
    tick(2);
    clear_logs();
    for (int i = 0; i < DEPTH; i++) drive_write(8'(i));
    tests_run++; if (full !== 1'b1 || count !== 5'd16) begin tests_failed++; $display("FAIL fill_full: got full=%b count=%0d want 1 16", full, count); end
    tests_run++; if (overflow !== 1'b0 || tx_en !== 1'b0) begin tests_failed++; $display("FAIL fill_quiet: got ovf=%b tx_en=%b want 0 0", overflow, tx_en); end
    drive_write(8'd99);
    tests_run++; if (overflow !== 1'b1 || count !== 5'd16) begin tests_failed++; $display("FAIL fill_overflow: got ovf=%b count=%0d want 1 16", overflow, count); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fill_ovf_clr: got %b want 0", overflow); end
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'd77; tick(1); ovf_clr = 1'b0; wr_en = 1'b0;
    tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL fill_set_wins: got %b want 1", overflow); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    busy_delay = 1; busy_hold = 3; busy_mode = 0;
    wait_frames(DEPTH, 3000, ok);
    tests_run++; if (!ok || launch_q.size() != DEPTH) begin tests_failed++; $display("FAIL fill_drain_count: got %0d want %0d", launch_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < launch_q.size(); i++) begin
      tests_run++; if (launch_q[i] !== 8'(i)) begin tests_failed++; $display("FAIL fill_drain[%0d]: got %0d want %0d", i, launch_q[i], i); end
    end
    tests_run++; if (empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0) begin
      tests_failed++; $display("FAIL fill_end: got empty=%b full=%b ovf=%b want 1 0 0", empty, full, overflow);
    end
  endtask

  task automatic test_start_timeout;
    int i;
    busy_mode = 2;
    tick(2);
    clear_logs();
    drive_write(8'hA5);
    i = 0;
    while (len_q.size() < 1 && i < TIMEOUT + 100) begin tick(1); i++; end
    tests_run++; if (len_q.size() != 1) begin tests_failed++; $display("FAIL timeout_wait: got %0d pulses want 1", len_q.size()); end
    else begin
      $display("[TB] timeout frame data=%0h pulse=%0d", launch_q[0], len_q[0]);
      tests_run++; if (len_q[0] != TIMEOUT || launch_q[0] !== 8'hA5) begin
        tests_failed++; $display("FAIL timeout_pulse: got len=%0d data=%0h want %0d a5", len_q[0], launch_q[0], TIMEOUT);
      end
    end
    tests_run++; if (start_err !== 1'b1 || tx_en !== 1'b0 || count !== 5'd0) begin
      tests_failed++; $display("FAIL timeout_state: got err=%b tx_en=%b count=%0d want 1 0 0", start_err, tx_en, count);
    end
    tick(5);
    tests_run++; if (launch_q.size() != 1) begin tests_failed++; $display("FAIL timeout_relaunch: got %0d launches want 1", launch_q.size()); end
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    tests_run++; if (start_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_clr: got %b want 0", start_err); end
  endtask

  task automatic test_simul_push_pop;
    bit ok;
    busy_mode = 3;
    busy = 1'b1;
    tick(1);
    clear_logs();
    drive_write(8'h11);
    tick(2);
    tests_run++; if (count !== 5'd1 || tx_en !== 1'b0) begin tests_failed++; $display("FAIL pp_setup: got count=%0d tx_en=%b want 1 0", count, tx_en); end
    busy = 1'b0; wr_en = 1'b1; wr_data = 8'h3C;
    @(posedge tx_clk); #1;
    wr_en = 1'b0;
    tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL pp_count: got %0d want 1", count); end
    tests_run++; if (tx_en !== 1'b1 || data_in !== 8'h11) begin tests_failed++; $display("FAIL pp_launch: got tx_en=%b data=%0h want 1 11", tx_en, data_in); end
    @(negedge tx_clk);
    busy_delay = 2; busy_hold = 5; busy_mode = 0;
    wait_frames(2, 500, ok);
    tests_run++; if (!ok || launch_q.size() != 2) begin tests_failed++; $display("FAIL pp_frames: got %0d want 2", launch_q.size()); end
    else begin
      tests_run++; if (launch_q[0] !== 8'h11 || launch_q[1] !== 8'h3C) begin
        tests_failed++; $display("FAIL pp_order: got %0h %0h want 11 3c", launch_q[0], launch_q[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int i;
    bit ok;
    busy_mode = 0; busy_delay = 2; busy_hold = 200;
    clear_logs();
    for (int k = 0; k < 4; k++) drive_write(8'($urandom));
    i = 0;
    while (!(busy && count == 5'd3) && i < 100) begin tick(1); i++; end
    tests_run++; if (!(busy && count == 5'd3)) begin tests_failed++; $display("FAIL midrst_setup: got busy=%b count=%0d want 1 3", busy, count); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (tx_en !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_async: got tx_en=%b count=%0d empty=%b want 0 0 1", tx_en, count, empty);
    end
    busy_mode = 2;
    #100;
    @(negedge tx_clk);
    rst = 1'b1;
    clear_logs();
    tick(50);
    tests_run++; if (launch_q.size() != 0 || tx_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_quiet: got %0d launches want 0", launch_q.size()); end
    drive_write(8'h5A);
    i = 0;
    while (!tx_en && i < 10) begin tick(1); i++; end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (tx_en !== 1'b0 || data_in !== 8'd0) begin
      tests_failed++; $display("FAIL startrst_async: got tx_en=%b data=%0h want 0 0", tx_en, data_in);
    end
    #100;
    @(negedge tx_clk);
    rst = 1'b1;
    busy_mode = 0; busy_delay = 2; busy_hold = 5;
    tick(1);
    clear_logs();
    drive_write(8'hC3);
    wait_frames(1, 200, ok);
    tests_run++; if (!ok || launch_q.size() != 1 || launch_q[0] !== 8'hC3) begin
      tests_failed++; $display("FAIL midrst_resume: got %0d frames first=%0h want 1 c3", launch_q.size(), (launch_q.size() > 0) ? launch_q[0] : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_ordered_drain();
    test_random_drain();
    test_fill_overflow();
    test_start_timeout();
    test_simul_push_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
